jtagstream_wb_bridge: RTL and testbench

- Sys-domain consumer of the JTAG byte stream after the async FIFO.
- Decodes the LiteX UART-bridge command protocol from RX bytes and masters a 32-bit Wishbone bus.
- Returns read data as TX bytes to the JTAG shift stage.
- Gives litex_server register access over JTAG.

---
 rtl/jtagstream_pkg.sv | 19 +
 rtl/jtagstream_wb_bridge_if.sv | 32 +++
 rtl/jtagstream_timeout.sv | 29 ++
 rtl/jtagstream_wb_bridge.sv | 137 +++++++++++++
 tb/tb_jtagstream_wb_bridge.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtagstream_pkg.sv
// Shared constants and FSM state type for the JTAG-stream to Wishbone bridge.
package jtagstream_pkg;

   localparam logic [7:0]  CMD_WRITE  = 8'h01;
   localparam logic [7:0]  CMD_READ   = 8'h02;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_ADDR,
      ST_WDATA,
      ST_WB_WR,
      ST_RD_REQ,
      ST_WB_RD,
      ST_TXD
   } state_t;

endpackage

// File: rtl/jtagstream_wb_bridge_if.sv
// Byte-stream (RX/TX) and Wishbone classic signals seen by the bridge.
interface jtagstream_wb_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 30
) ();

   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic [7:0]            tx_data;
   logic                  tx_valid;
   logic                  tx_ready;
   logic [ADDR_WIDTH-1:0] wb_adr;
   logic [31:0]           wb_dat_w;
   logic [31:0]           wb_dat_r;
   logic [3:0]            wb_sel;
   logic                  wb_cyc;
   logic                  wb_stb;
   logic                  wb_we;
   logic                  wb_ack;
   logic                  wb_err;

   modport master (
      input  rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
      output rx_ready, tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
      input  rx_ready, tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
   );

endinterface

// File: rtl/jtagstream_timeout.sv
// Loadable down-counter: expired is raised on the LIMIT-th enabled cycle after a load.
module jtagstream_timeout #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= W'(LIMIT - 1);
      end else if (load) begin
         count <= W'(LIMIT - 1);
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   // A load in the expiry cycle (byte arriving just in time) wins.
   assign expired = en && !load && (count == '0);

endmodule

// File: rtl/jtagstream_wb_bridge.sv
// Decodes the LiteX UART-bridge protocol from the JTAG byte stream and masters Wishbone.
module jtagstream_wb_bridge #(
   parameter int unsigned ADDR_WIDTH = 30,
   parameter int unsigned RX_TIMEOUT = 1000000,
   parameter int unsigned WB_TIMEOUT = 1024
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
   jtagstream_wb_bridge_if.master bus,
   output logic [7:0]             err_count
);

   import jtagstream_pkg::*;

   state_t      state, state_next;
   logic        is_write;
   logic [7:0]  len;
   logic [1:0]  byte_cnt;
   logic [23:0] addr_sr;
   logic [31:0] addr_full;
   logic [31:0] tx_shift;
   logic        rx_fire, tx_fire, last_byte;
   logic        rx_en, rx_load, rx_to_exp, wb_to_exp;
   logic        bus_phase, wb_done, wb_fail;
   logic        rx_ready_d, cyc_d, we_d, tx_valid_d;

   assign rx_fire   = bus.rx_valid && bus.rx_ready;
   assign tx_fire   = bus.tx_valid && bus.tx_ready;
   assign last_byte = (byte_cnt == 2'(WORD_BYTES - 1));
   assign addr_full = {addr_sr, bus.rx_data};
   assign bus_phase = (state == ST_WB_WR) || (state == ST_WB_RD);
   assign wb_done   = bus_phase && (bus.wb_ack || bus.wb_err || wb_to_exp);
   assign wb_fail   = wb_done && !bus.wb_ack;
   assign rx_en     = (state == ST_LEN) || (state == ST_ADDR) || (state == ST_WDATA);
   assign rx_load   = rx_fire || !rx_en;
   assign bus.tx_data = tx_shift[31:24];

   jtagstream_timeout #(.LIMIT(RX_TIMEOUT)) u_rx_timeout (
      .clk(sys_clk), .rst_n(sys_rst_n), .load(rx_load), .en(rx_en), .expired(rx_to_exp)
   );

   jtagstream_timeout #(.LIMIT(WB_TIMEOUT)) u_wb_timeout (
      .clk(sys_clk), .rst_n(sys_rst_n), .load(!bus.wb_cyc), .en(bus.wb_cyc), .expired(wb_to_exp)
   );

   // Outputs are registered from the next state so they read 0 while in reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state        <= ST_IDLE;
         bus.rx_ready <= 1'b0;
         bus.wb_cyc   <= 1'b0;
         bus.wb_stb   <= 1'b0;
         bus.wb_we    <= 1'b0;
         bus.wb_sel   <= '0;
         bus.tx_valid <= 1'b0;
      end else begin
         state        <= state_next;
         bus.rx_ready <= rx_ready_d;
         bus.wb_cyc   <= cyc_d;
         bus.wb_stb   <= cyc_d;
         bus.wb_we    <= we_d;
         bus.wb_sel   <= cyc_d ? '1 : '0;
         bus.tx_valid <= tx_valid_d;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:   if (rx_fire && (bus.rx_data == CMD_WRITE || bus.rx_data == CMD_READ))
                       state_next = ST_LEN;
         ST_LEN:    if (rx_fire) state_next = ST_ADDR;
         ST_ADDR:   if (rx_fire && last_byte)
                       state_next = (len == '0) ? ST_IDLE : (is_write ? ST_WDATA : ST_RD_REQ);
         ST_WDATA:  if (rx_fire && last_byte) state_next = ST_WB_WR;
         ST_WB_WR:  if (wb_done) state_next = (len == 8'd1) ? ST_IDLE : ST_WDATA;
         ST_RD_REQ: state_next = ST_WB_RD;
         ST_WB_RD:  if (wb_done) state_next = ST_TXD;
         ST_TXD:    if (tx_fire && last_byte) state_next = (len == 8'd1) ? ST_IDLE : ST_RD_REQ;
         default:   state_next = ST_IDLE;
      endcase
      if (rx_to_exp) state_next = ST_IDLE;
   end

   always_comb begin
      rx_ready_d = state_next inside {ST_IDLE, ST_LEN, ST_ADDR, ST_WDATA};
      cyc_d      = state_next inside {ST_WB_WR, ST_RD_REQ, ST_WB_RD};
      we_d       = (state_next == ST_WB_WR);
      tx_valid_d = (state_next == ST_TXD);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         is_write     <= 1'b0;
         len          <= '0;
         byte_cnt     <= '0;
         addr_sr      <= '0;
         tx_shift     <= '0;
         bus.wb_adr   <= '0;
         bus.wb_dat_w <= '0;
         err_count    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               byte_cnt <= '0;
               if (rx_fire) is_write <= (bus.rx_data == CMD_WRITE);
            end
            ST_LEN:  if (rx_fire) len <= bus.rx_data;
            ST_ADDR: if (rx_fire) begin
               addr_sr  <= addr_full[23:0];
               byte_cnt <= byte_cnt + 1'b1;
               if (last_byte) bus.wb_adr <= ADDR_WIDTH'(addr_full >> 2);
            end
            ST_WDATA: if (rx_fire) begin
               bus.wb_dat_w <= {bus.wb_dat_w[23:0], bus.rx_data};
               byte_cnt     <= byte_cnt + 1'b1;
            end
            ST_WB_WR: if (wb_done) begin
               bus.wb_adr <= bus.wb_adr + 1'b1;
               len        <= len - 1'b1;
            end
            ST_WB_RD: if (wb_done) tx_shift <= bus.wb_ack ? bus.wb_dat_r : '1;
            ST_TXD: if (tx_fire) begin
               tx_shift <= {tx_shift[23:0], 8'h00};
               byte_cnt <= byte_cnt + 1'b1;
               if (last_byte) begin
                  bus.wb_adr <= bus.wb_adr + 1'b1;
                  len        <= len - 1'b1;
               end
            end
            default: ;
         endcase
         if (wb_fail && err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_jtagstream_wb_bridge.sv
// Randomized bench: frames go to the bridge, bus accesses and TX bytes are compared with a frame-level model.
module tb_jtagstream_wb_bridge;

   localparam int unsigned AW  = 30;
   localparam int unsigned RXT = 16;
   localparam int unsigned WBT = 8;

   typedef struct {
      bit          we;
      bit [AW-1:0] adr;
      bit [31:0]   dat;
      bit          fail;
      bit          to;
      int          cycles;
   } acc_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] err_count;

   int n_checks = 0, n_errors = 0;
   int sel_bad = 0, stall_bad = 0;
   int slave_mode = 0;   // 0 ack, 1 wb_err, 2 silent
   int tx_mode = 0;      // 0 always ready, 1 toggle, 2 random
   int exp_err = 0;

   acc_t      exp_acc[$], act_acc[$];
   bit [7:0]  exp_tx[$], act_tx[$];
   bit [31:0] slv_mem [bit [AW-1:0]];
   bit [31:0] ref_mem [bit [AW-1:0]];

   always #5 sys_clk = ~sys_clk;

   jtagstream_wb_bridge_if #(.ADDR_WIDTH(AW)) bus ();

   jtagstream_wb_bridge #(.ADDR_WIDTH(AW), .RX_TIMEOUT(RXT), .WB_TIMEOUT(WBT)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus), .err_count(err_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit [31:0] init_word(input bit [AW-1:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'hA5C3_0F11;
   endfunction

   function automatic bit [31:0] ref_rd(input bit [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   // Wishbone slave with random ack latency (>= 2) and an access monitor.
   initial begin
      bit   pc;
      int   cnt, lat;
      acc_t cur;
      pc = 0; cnt = 0; lat = 2; cur = '{default: 0};
      bus.wb_ack = 1'b0; bus.wb_err = 1'b0; bus.wb_dat_r = '0;
      forever begin
         @(posedge sys_clk); #1;
         if (pc && !bus.wb_cyc) act_acc.push_back(cur);
         if (bus.wb_cyc && bus.wb_sel !== 4'hF) sel_bad++;
         if (bus.wb_cyc) begin
            if (!pc) begin
               cnt = 0;
               lat = $urandom_range(2, 4);
               cur.fail = (slave_mode != 0);
            end
            cnt++;
            cur.cycles = cnt;
            cur.we  = bus.wb_we;
            cur.adr = bus.wb_adr;
            cur.dat = bus.wb_we ? bus.wb_dat_w : 32'h0;
            bus.wb_ack = (slave_mode == 0) && (cnt == lat);
            bus.wb_err = (slave_mode == 1) && (cnt == lat);
            if (bus.wb_ack) begin
               if (bus.wb_we) slv_mem[bus.wb_adr] = bus.wb_dat_w;
               else bus.wb_dat_r = slv_mem.exists(bus.wb_adr) ? slv_mem[bus.wb_adr] : init_word(bus.wb_adr);
            end
         end else begin
            bus.wb_ack = 1'b0;
            bus.wb_err = 1'b0;
         end
         pc = bus.wb_cyc;
      end
   end

   // TX sink: records handshakes and flags any change of a stalled byte.
   initial begin
      bit       pv, pr, r;
      bit [7:0] pd;
      pv = 0; pr = 0; pd = 0;
      bus.tx_ready = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         if (pv && pr) act_tx.push_back(pd);
         else if (pv && sys_rst_n && !(bus.tx_valid === 1'b1 && bus.tx_data === pd)) stall_bad++;
         case (tx_mode)
            0:       r = 1'b1;
            1:       r = !pr;
            default: r = 1'($urandom_range(0, 1));
         endcase
         bus.tx_ready = r;
         pv = bus.tx_valid;
         pr = r;
         pd = bus.tx_data;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk); #1;
      end
   endtask

   task automatic send_byte(input bit [7:0] b);
      bit r;
      int n;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      n = 0;
      do begin
         r = bus.rx_ready;
         tick(1);
         n++;
      end while (!r && n < 300);
      check("rx_accept", 32'(r), 32'd1);
      bus.rx_valid = 1'b0;
      tick($urandom_range(0, 2));
   endtask

   task automatic wait_idle();
      int quiet, n;
      quiet = 0; n = 0;
      while (quiet < 4 && n < 3000) begin
         tick(1);
         n++;
         if (bus.rx_ready && !bus.wb_cyc && !bus.tx_valid) quiet++;
         else quiet = 0;
      end
      check("idle_reached", 32'(quiet), 32'd4);
   endtask

   task automatic frame(input bit [7:0] cmd, input bit [7:0] len, input bit [31:0] addr,
                        input bit [31:0] w0);
      bit [AW-1:0] a;
      bit [31:0]   w;
      acc_t        e;
      a = addr[AW+1:2];
      send_byte(cmd);
      send_byte(len);
      for (int k = 3; k >= 0; k--) send_byte(addr[k*8 +: 8]);
      for (int i = 0; i < int'(len); i++) begin
         e.we     = (cmd == 8'h01);
         e.adr    = a;
         e.fail   = (slave_mode != 0);
         e.to     = (slave_mode == 2);
         e.cycles = WBT;
         e.dat    = 32'h0;
         if (e.we) begin
            w = (i == 0) ? w0 : $urandom;
            e.dat = w;
            if (!e.fail) ref_mem[a] = w;
            for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
         end else begin
            w = e.fail ? 32'hFFFF_FFFF : ref_rd(a);
            for (int k = 3; k >= 0; k--) exp_tx.push_back(w[k*8 +: 8]);
         end
         if (e.fail && exp_err < 255) exp_err++;
         exp_acc.push_back(e);
         a = a + 1'b1;
      end
      wait_idle();
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_nacc"}, 32'(act_acc.size()), 32'(exp_acc.size()));
      n = (act_acc.size() < exp_acc.size()) ? act_acc.size() : exp_acc.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_we"}, 32'(act_acc[i].we), 32'(exp_acc[i].we));
         check({tag, "_adr"}, 32'(act_acc[i].adr), 32'(exp_acc[i].adr));
         check({tag, "_fail"}, 32'(act_acc[i].fail), 32'(exp_acc[i].fail));
         if (exp_acc[i].we) check({tag, "_dat_w"}, act_acc[i].dat, exp_acc[i].dat);
         if (exp_acc[i].to) check({tag, "_to_cycles"}, 32'(act_acc[i].cycles), 32'(exp_acc[i].cycles));
      end
      check({tag, "_ntx"}, 32'(act_tx.size()), 32'(exp_tx.size()));
      n = (act_tx.size() < exp_tx.size()) ? act_tx.size() : exp_tx.size();
      for (int i = 0; i < n; i++) check({tag, "_tx"}, 32'(act_tx[i]), 32'(exp_tx[i]));
      check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
      act_acc.delete(); exp_acc.delete(); act_tx.delete(); exp_tx.delete();
   endtask

   task automatic preset(input bit [AW-1:0] a, input bit [31:0] v);
      slv_mem[a] = v;
      ref_mem[a] = v;
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = '0;
      sys_rst_n    = 1'b0;
      tick(3);
      check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_cyc_stb_we", {29'd0, bus.wb_cyc, bus.wb_stb, bus.wb_we}, 32'd0);
      check("rst_adr", 32'(bus.wb_adr), 32'd0);
      check("rst_dat_w", bus.wb_dat_w, 32'd0);
      check("rst_sel", 32'(bus.wb_sel), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      sys_rst_n = 1'b1;
      tick(2);

      frame(8'h01, 8'd1, 32'h0000_1000, 32'hDEAD_BEEF);
      compare("wr1");

      preset(30'd2, 32'h1122_3344);
      preset(30'd3, 32'h5566_7788);
      tx_mode = 1;
      frame(8'h02, 8'd2, 32'h0000_0008, 32'h0);
      compare("rd_burst");

      tx_mode = 2;
      send_byte(8'h7F);
      frame(8'h02, 8'd0, 32'h0, 32'h0);
      frame(8'h01, 8'd1, 32'h0000_0040, 32'h0BAD_F00D);
      compare("garbage_len0");

      send_byte(8'h01);
      send_byte(8'h01);
      send_byte(8'h00);
      tick(RXT + 4);
      frame(8'h02, 8'd1, 32'h0, 32'h0);
      compare("rx_timeout");

      slave_mode = 2;
      frame(8'h02, 8'd1, 32'h0000_0080, 32'h0);
      compare("wb_timeout");
      slave_mode = 1;
      frame(8'h01, 8'd1, 32'h0000_0084, 32'h1234_5678);
      compare("wb_err");

      slave_mode = 0;
      frame(8'h01, 8'd2, 32'hFFFF_FFFC, 32'hCAFE_F00D);
      frame(8'h02, 8'd2, 32'hFFFF_FFFC, 32'h0);
      compare("adr_wrap");

      repeat (25) begin
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom_range(16, 255)));
         slave_mode = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
         tx_mode    = $urandom_range(0, 2);
         frame(8'($urandom_range(1, 2)), 8'($urandom_range(0, 3)),
               32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3)), $urandom);
         compare("random");
      end

      slave_mode = 1;
      tx_mode    = 0;
      repeat (255) begin
         frame(8'h01, 8'd1, 32'h0000_0100, $urandom);
         compare("saturate");
      end

      slave_mode = 2;
      send_byte(8'h02);
      send_byte(8'h01);
      for (int k = 0; k < 4; k++) send_byte(8'h00);
      for (int n = 0; n < 20 && !bus.wb_cyc; n++) tick(1);
      check("mid_cyc_seen", 32'(bus.wb_cyc), 32'd1);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_cyc_stb", {30'd0, bus.wb_cyc, bus.wb_stb}, 32'd0);
      check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("mid_rst_err_count", 32'(err_count), 32'd0);
      tick(2);
      sys_rst_n = 1'b1;
      tick(2);
      exp_err = 0;
      act_acc.delete(); exp_acc.delete(); act_tx.delete(); exp_tx.delete();
      slave_mode = 0;
      frame(8'h01, 8'd1, 32'h0000_0200, 32'h5A5A_1234);
      frame(8'h02, 8'd1, 32'h0000_0200, 32'h0);
      compare("post_rst");

      check("sel_while_cyc", 32'(sel_bad), 32'd0);
      check("tx_stall_stable", 32'(stall_bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
